// File: rtl/rx_alu_frontend.sv
// rx_alu_frontend: collects a three-byte command (operand A, operand B, opcode)
// from the UART receiver, drives it to the combinational ALU, and hands the
// latched ALU result to the UART transmitter with a start/busy handshake.
//
// Ports:
//   i_clock, i_reset     clock; synchronous active-high reset
//   i_rx_word            receiver word, first-received bit at MSB, optional
//                        trailing parity bit in bit 0
//   i_rx_done            receiver done level (one event per rising edge)
//   i_alu_result         combinational ALU result
//   i_tx_busy            transmitter busy
//   o_data_a, o_data_b   operands to ALU (held until overwritten)
//   o_opcode             opcode to ALU (held until overwritten)
//   o_tx_data            byte for transmitter (held until next capture)
//   o_tx_start           one-cycle transmit request
//   o_parity_error       one-cycle pulse, bad-parity byte discarded
//   o_overrun            one-cycle pulse, byte received while transmitting
module rx_alu_frontend #(
  parameter int unsigned N_DATA       = 8,
  parameter int unsigned PARITY_CHECK = 1,
  parameter int unsigned PARITY_ODD   = 0,
  parameter int unsigned NB_OPCODE    = 6
) (
  input  logic                           i_clock,
  input  logic                           i_reset,
  input  logic [N_DATA+PARITY_CHECK-1:0] i_rx_word,
  input  logic                           i_rx_done,
  input  logic [N_DATA-1:0]              i_alu_result,
  input  logic                           i_tx_busy,
  output logic [N_DATA-1:0]              o_data_a,
  output logic [N_DATA-1:0]              o_data_b,
  output logic [NB_OPCODE-1:0]           o_opcode,
  output logic [N_DATA-1:0]              o_tx_data,
  output logic                           o_tx_start,
  output logic                           o_parity_error,
  output logic                           o_overrun
);

  localparam int unsigned W_WORD = N_DATA + PARITY_CHECK;

  typedef enum logic [2:0] {
    ST_A,
    ST_B,
    ST_OP,
    ST_TX_REQ,
    ST_TX_WAIT,
    ST_TX_DRAIN
  } state_t;

  state_t                state, state_next;
  logic                  done_d;
  logic                  rx_event;
  logic [N_DATA-1:0]     rx_field;
  logic [N_DATA-1:0]     rx_byte;
  logic                  good;

  logic [N_DATA-1:0]     data_a_next, data_b_next, tx_data_next;
  logic [NB_OPCODE-1:0]  opcode_next;
  logic                  tx_start_next, parity_error_next, overrun_next;

  // One event per receiver done rising edge.
  assign rx_event = i_rx_done & ~done_d;

  // Undo shift-register order so the first-received bit lands in byte[0].
  always_comb begin
    rx_field = i_rx_word[W_WORD-1:PARITY_CHECK];
    rx_byte  = '0;
    for (int unsigned i = 0; i < N_DATA; i++) begin
      rx_byte[i] = rx_field[N_DATA-1-i];
    end
    if (PARITY_CHECK == 0) begin
      good = 1'b1;
    end else begin
      good = (((^rx_byte) ^ i_rx_word[0]) == 1'(PARITY_ODD));
    end
  end

  // State and registered outputs.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state          <= ST_A;
      done_d         <= 1'b1;
      o_data_a       <= '0;
      o_data_b       <= '0;
      o_opcode       <= '0;
      o_tx_data      <= '0;
      o_tx_start     <= 1'b0;
      o_parity_error <= 1'b0;
      o_overrun      <= 1'b0;
    end else begin
      state          <= state_next;
      done_d         <= i_rx_done;
      o_data_a       <= data_a_next;
      o_data_b       <= data_b_next;
      o_opcode       <= opcode_next;
      o_tx_data      <= tx_data_next;
      o_tx_start     <= tx_start_next;
      o_parity_error <= parity_error_next;
      o_overrun      <= overrun_next;
    end
  end

  // Next-state and next-output decode.
  always_comb begin
    state_next        = state;
    data_a_next       = o_data_a;
    data_b_next       = o_data_b;
    opcode_next       = o_opcode;
    tx_data_next      = o_tx_data;
    tx_start_next     = 1'b0;
    parity_error_next = 1'b0;
    overrun_next      = 1'b0;

    case (state)
      ST_A: begin
        if (rx_event) begin
          if (good) begin
            data_a_next = rx_byte;
            state_next  = ST_B;
          end else begin
            parity_error_next = 1'b1;
          end
        end
      end
      ST_B: begin
        if (rx_event) begin
          if (good) begin
            data_b_next = rx_byte;
            state_next  = ST_OP;
          end else begin
            parity_error_next = 1'b1;
          end
        end
      end
      ST_OP: begin
        if (rx_event) begin
          if (good) begin
            opcode_next = rx_byte[NB_OPCODE-1:0];
            state_next  = ST_TX_REQ;
          end else begin
            parity_error_next = 1'b1;
          end
        end
      end
      // ALU inputs settled a clock ago; result is safe to sample here.
      ST_TX_REQ: begin
        overrun_next = rx_event;
        if (!i_tx_busy) begin
          tx_data_next  = i_alu_result;
          tx_start_next = 1'b1;
          state_next    = ST_TX_WAIT;
        end
      end
      ST_TX_WAIT: begin
        overrun_next = rx_event;
        if (i_tx_busy) begin
          state_next = ST_TX_DRAIN;
        end
      end
      ST_TX_DRAIN: begin
        overrun_next = rx_event;
        if (!i_tx_busy) begin
          state_next = ST_A;
        end
      end
      default: begin
        state_next = ST_A;
      end
    endcase
  end

endmodule

// File: tb/tb_rx_alu_frontend.sv
// Directed bench for rx_alu_frontend (N_DATA=8, even parity): a vector table
// of command words plus hand sequences for busy, overrun and reset cases.
module tb_rx_alu_frontend;

  logic       clk = 1'b0;
  logic       rst;
  logic [8:0] rx_word;
  logic       rx_done;
  logic [7:0] alu_result;
  logic       tx_busy;
  logic [7:0] data_a, data_b, tx_data;
  logic [5:0] opcode;
  logic       tx_start, parity_error, overrun;

  logic       force_busy = 1'b0;
  logic       model_en   = 1'b1;
  int         mdl_cnt    = 0;

  int checks = 0;
  int errors = 0;

  int cyc = 0, rise_cyc = 0, start_cyc = 0;
  int n_start = 0, n_perr = 0, n_ovr = 0, n_long = 0;
  logic [7:0] last_txd = 8'h00;
  logic done_prev = 1'b0, start_prev = 1'b0, perr_prev = 1'b0, ovr_prev = 1'b0;

  rx_alu_frontend #(
    .N_DATA(8), .PARITY_CHECK(1), .PARITY_ODD(0), .NB_OPCODE(6)
  ) dut (
    .i_clock       (clk),
    .i_reset       (rst),
    .i_rx_word     (rx_word),
    .i_rx_done     (rx_done),
    .i_alu_result  (alu_result),
    .i_tx_busy     (tx_busy),
    .o_data_a      (data_a),
    .o_data_b      (data_b),
    .o_opcode      (opcode),
    .o_tx_data     (tx_data),
    .o_tx_start    (tx_start),
    .o_parity_error(parity_error),
    .o_overrun     (overrun)
  );

  always #5 clk = ~clk;

  // ALU model: A + B.
  assign alu_result = data_a + data_b;

  // Transmitter model: busy for 6 clocks after each start.
  assign tx_busy = force_busy | (mdl_cnt != 0);
  always @(posedge clk) begin
    if (tx_start && model_en) mdl_cnt <= 6;
    else if (mdl_cnt != 0)    mdl_cnt <= mdl_cnt - 1;
  end

  // Pulse monitor, sampled on the falling edge.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (rx_done && !done_prev) rise_cyc = cyc;
    done_prev = rx_done;
    if (tx_start) begin
      n_start   = n_start + 1;
      last_txd  = tx_data;
      start_cyc = cyc;
    end
    if (parity_error) n_perr = n_perr + 1;
    if (overrun)      n_ovr  = n_ovr + 1;
    if ((tx_start && start_prev) || (parity_error && perr_prev) || (overrun && ovr_prev))
      n_long = n_long + 1;
    start_prev = tx_start;
    perr_prev  = parity_error;
    ovr_prev   = overrun;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks = checks + 1;
    if (act != exp) begin
      errors = errors + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [8:0] word, input int hold, input int gap);
    rx_word = word;
    rx_done = 1'b1;
    tick(hold);
    rx_done = 1'b0;
    tick(gap);
  endtask

  typedef struct {
    logic [8:0] word;
    int         hold;
    logic [7:0] a;
    logic [7:0] b;
    logic [5:0] op;
    int         d_perr;
    int         d_start;
    logic [7:0] txd;
  } vec_t;

  vec_t vecs[8];
  int p0, s0, o0;

  initial begin
    // word encodings: byte 0x05->0x140, 0x03->0x180, 0x20->0x009,
    // 0x12->0x090, 0x21->0x108, 0x07->0x1C1; 0x141/0x109 have bad parity
    vecs[0] = '{9'h140,  4, 8'h05, 8'h00, 6'h00, 0, 0, 8'h00};
    vecs[1] = '{9'h180,  4, 8'h05, 8'h03, 6'h00, 0, 0, 8'h00};
    vecs[2] = '{9'h009,  4, 8'h05, 8'h03, 6'h20, 0, 1, 8'h08};
    vecs[3] = '{9'h141,  4, 8'h05, 8'h03, 6'h20, 1, 0, 8'h00};
    vecs[4] = '{9'h090, 20, 8'h12, 8'h03, 6'h20, 0, 0, 8'h00};
    vecs[5] = '{9'h109,  4, 8'h12, 8'h03, 6'h20, 1, 0, 8'h00};
    vecs[6] = '{9'h108,  4, 8'h12, 8'h21, 6'h20, 0, 0, 8'h00};
    vecs[7] = '{9'h1C1,  4, 8'h12, 8'h21, 6'h07, 0, 1, 8'h33};

    rst = 1'b1; rx_word = 9'h000; rx_done = 1'b0;
    tick(3);
    check("reset_a",   int'(data_a), 0);
    check("reset_b",   int'(data_b), 0);
    check("reset_op",  int'(opcode), 0);
    check("reset_txd", int'(tx_data), 0);
    check("reset_start_perr_ovr", int'({tx_start, parity_error, overrun}), 0);
    rst = 1'b0;
    tick(2);

    // Table-driven command traffic.
    for (int i = 0; i < 8; i++) begin
      p0 = n_perr; s0 = n_start; o0 = n_ovr;
      send(vecs[i].word, vecs[i].hold, 16);
      check($sformatf("v%0d_a", i),     int'(data_a), int'(vecs[i].a));
      check($sformatf("v%0d_b", i),     int'(data_b), int'(vecs[i].b));
      check($sformatf("v%0d_op", i),    int'(opcode), int'(vecs[i].op));
      check($sformatf("v%0d_perr", i),  n_perr - p0, vecs[i].d_perr);
      check($sformatf("v%0d_start", i), n_start - s0, vecs[i].d_start);
      check($sformatf("v%0d_ovr", i),   n_ovr - o0, 0);
      if (vecs[i].d_start != 0)
        check($sformatf("v%0d_txd", i), int'(last_txd), int'(vecs[i].txd));
    end

    // Transmitter busy when opcode arrives: start waits for busy to fall.
    send(9'h140, 4, 4);
    send(9'h180, 4, 4);
    force_busy = 1'b1;
    s0 = n_start;
    send(9'h009, 4, 10);
    check("busy_op", int'(opcode), 'h20);
    check("busy_no_start", n_start - s0, 0);
    force_busy = 1'b0;
    tick(4);
    check("busy_one_start", n_start - s0, 1);
    check("busy_txd", int'(last_txd), 'h08);
    tick(16);
    send(9'h090, 4, 4);
    check("busy_back_to_a", int'(data_a), 'h12);

    // Overrun: transmitter never raises busy, so the FSM parks in TX_WAIT.
    model_en = 1'b0;
    send(9'h108, 4, 4);
    s0 = n_start;
    send(9'h1C1, 4, 4);
    check("latency", start_cyc - rise_cyc, 2);
    check("ovr_start", n_start - s0, 1);
    check("ovr_txd", int'(last_txd), 'h33);
    p0 = n_perr; o0 = n_ovr;
    send(9'h140, 4, 2);
    check("ovr_wait_pulse", n_ovr - o0, 1);
    check("ovr_a_kept", int'(data_a), 'h12);
    send(9'h141, 4, 2);
    check("ovr_bad_parity_ovr", n_ovr - o0, 2);
    check("ovr_no_parity_err", n_perr - p0, 0);
    force_busy = 1'b1;
    tick(3);
    send(9'h180, 4, 2);
    check("ovr_drain_pulse", n_ovr - o0, 3);
    force_busy = 1'b0;
    tick(3);
    model_en = 1'b1;
    check("ovr_after_a", int'(data_a), 'h12);
    check("ovr_after_b", int'(data_b), 'h21);

    // Reset mid-command with rx_done held high through reset.
    send(9'h140, 4, 2);
    check("rst_pre_a", int'(data_a), 'h05);
    rx_word = 9'h180;
    rx_done = 1'b1;
    tick(2);
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    check("rst_a", int'(data_a), 0);
    check("rst_b", int'(data_b), 0);
    check("rst_op", int'(opcode), 0);
    check("rst_txd", int'(tx_data), 0);
    tick(4);
    check("rst_no_capture_a", int'(data_a), 0);
    check("rst_no_capture_b", int'(data_b), 0);
    rx_done = 1'b0;
    tick(2);
    s0 = n_start;
    send(9'h140, 4, 4);
    send(9'h180, 4, 4);
    send(9'h009, 4, 16);
    check("rst_cmd_a", int'(data_a), 'h05);
    check("rst_cmd_start", n_start - s0, 1);
    check("rst_cmd_txd", int'(last_txd), 'h08);

    check("pulse_width", n_long, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
